// File: rtl/br_cdc_toggle_handshake_src.sv
`default_nettype none
// ============================================================================
// Module   : br_cdc_toggle_handshake_src
// Purpose  : Source side of a toggle req/ack CDC handshake carrying a data word.
// Options  : BR_CDC_TOGGLE_HANDSHAKE_SRC_TIMEOUT_EN (sticky ack-timeout flag),
//            BR_ASSERT_ON (integration assertions)
// Revision : 1.0 - initial release
// ============================================================================
module br_cdc_toggle_handshake_src #(
    parameter int WIDTH              = 8,
    parameter int MIN_TOGGLE_GAP     = 0,
    parameter int ACK_TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             src_req_toggle,
    output logic [WIDTH-1:0] src_data,
    input  logic             ack_toggle_synced,
    output logic             busy,
    output logic             timeout_error
);

    localparam int c_GAP_W = (MIN_TOGGLE_GAP > 0) ? $clog2(MIN_TOGGLE_GAP + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_INIT =
        (MIN_TOGGLE_GAP > 0) ? c_GAP_W'(MIN_TOGGLE_GAP - 1) : '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        HOLDOFF  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_GAP_W-1:0] w_gap_cnt_nxt;
    logic               r_req;
    logic [WIDTH-1:0]   r_data;
    logic               w_accept;

    if (WIDTH < 1) begin : g_bad_width
        $error("br_cdc_toggle_handshake_src: WIDTH must be >= 1");
    end
    if (ACK_TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cfg
        $error("br_cdc_toggle_handshake_src: ACK_TIMEOUT_CYCLES must be >= 2");
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        w_accept      = 1'b0;
        case (r_state)
            IDLE: begin
                if (push_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // The destination has caught up once its ack level mirrors our request level.
                if (ack_toggle_synced == r_req) begin
                    if (MIN_TOGGLE_GAP == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = HOLDOFF;
                        w_gap_cnt_nxt = c_GAP_INIT;
                    end
                end
            end
            HOLDOFF: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_req     <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            if (w_accept) begin
                r_req  <= ~r_req;
                r_data <= push_data;
            end
        end
    end

    assign push_ready     = (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign src_req_toggle = r_req;
    assign src_data       = r_data;

`ifdef BR_CDC_TOGGLE_HANDSHAKE_SRC_TIMEOUT_EN
    localparam int c_TO_W = $clog2(ACK_TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(ACK_TIMEOUT_CYCLES);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;

    // Waiting continues after the flag is raised; a late ack still completes normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if ((r_state == WAIT_ACK) && (r_to_cnt != c_TO_LIMIT)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == (c_TO_LIMIT - 1'b1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_error = r_timeout;
`else
    assign timeout_error = 1'b0;
`endif

`ifdef BR_ASSERT_ON
    a_push_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (push_valid && !push_ready) |=> (push_valid && $stable(push_data)))
        else $error("push_valid/push_data changed while stalled");

    a_ack_only_in_wait : assert property (@(posedge clk) disable iff (!rst_n)
        (r_state != WAIT_ACK) |-> (ack_toggle_synced == r_req))
        else $error("ack toggled outside WAIT_ACK");
`endif

endmodule
`default_nettype wire
